// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by fetch_seq and its testbench.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HALT
    } fetch_state_e;

    localparam logic [4:0]  OPC_HALT     = 5'b00000;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
// Carry-out is not exported; callers use modular 16-bit sums.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    logic [15:0] g;
    logic [15:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic [15:0] c;
        logic        gc;
        logic        gg;
        logic        gp;
        c  = '0;
        gc = cin;
        for (int k = 0; k < 4; k++) begin
            gg = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp = &p[4*k +: 4];
            c[4*k] = gc;
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
            gc = gg | (gp & gc);
        end
        sum = p ^ c;
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues one 16-bit read at
// a time, buffers one instruction for decode and applies redirects.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        decode_stall,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] instr_pc,
    output logic [15:0] instr_pc_2,
    output logic        halted,
    output logic        align_err
);

    fetch_state_e state_q, state_d;

    logic [15:0] pc_q;
    logic [15:0] pc_plus2;
    logic [15:0] instr_q;
    logic [15:0] instr_pc_q;
    logic [15:0] instr_pc_2_q;
    logic        instr_valid_q;
    logic        halted_q;
    logic        align_err_q;
    logic        out_free;
    logic        is_halt;
    logic        req;
    logic        capture;

    cla16 u_pc_add (
        .a   (pc_q),
        .b   (16'h0002),
        .cin (1'b0),
        .sum (pc_plus2)
    );

    assign out_free = !instr_valid_q || !decode_stall;
    assign is_halt  = (imem_data[15:11] == OPC_HALT);

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req = out_free;
                if (req) state_d = imem_ready ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                req = 1'b1;
                if (imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    capture = 1'b1;
                    state_d = is_halt ? S_HALT : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_valid) state_d = S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Only wait in DROP while an accepted request is still in flight.
        if (redirect_valid) begin
            capture = 1'b0;
            unique case (state_q)
                S_IDLE:  state_d = (req && imem_ready) ? S_DROP : S_IDLE;
                S_REQ:   state_d = imem_ready ? S_DROP : S_IDLE;
                S_WAIT:  state_d = imem_valid ? S_IDLE : S_DROP;
                S_DROP:  state_d = imem_valid ? S_IDLE : S_DROP;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_pc_q    <= 16'h0000;
            instr_pc_2_q  <= 16'h0002;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            align_err_q <= redirect_valid & redirect_pc[0];
            if (redirect_valid) begin
                pc_q          <= {redirect_pc[15:1], 1'b0};
                instr_valid_q <= 1'b0;
                halted_q      <= 1'b0;
            end else if (capture) begin
                pc_q          <= pc_plus2;
                instr_q       <= imem_data;
                instr_pc_q    <= pc_q;
                instr_pc_2_q  <= pc_plus2;
                instr_valid_q <= 1'b1;
                halted_q      <= is_halt;
            end else if (instr_valid_q && !decode_stall) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign imem_req    = req & rst_n;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign instr_pc_2  = instr_pc_2_q;
    assign halted      = halted_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed testbench for fetch_seq with a 1- or 2-cycle memory model.
// Inputs change and outputs are sampled just after the falling edge.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        decode_stall;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_2;
    logic        halted;
    logic        align_err;

    int          nchk = 0;
    int          npass = 0;
    int          mem_lat = 1;
    logic [15:0] halt_addr = 16'hFFFF;

    logic        acc1, acc2;
    logic [15:0] a1, a2;

    always #5 clk = ~clk;

    fetch_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .decode_stall   (decode_stall),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .instr_pc_2     (instr_pc_2),
        .halted         (halted),
        .align_err      (align_err)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        if (addr == halt_addr) return 16'h0000;
        return 16'h4000 | addr;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1 <= 1'b0;
            acc2 <= 1'b0;
            a1   <= '0;
            a2   <= '0;
        end else begin
            acc1 <= imem_req && imem_ready;
            a1   <= imem_addr;
            acc2 <= acc1;
            a2   <= a1;
        end
    end

    assign imem_valid = (mem_lat == 1) ? acc1 : acc2;
    assign imem_data  = mem_word((mem_lat == 1) ? a1 : a2);

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_ready     = 1'b1;
        decode_stall   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        imem_ready     = 1'b1;
        decode_stall   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        mem_lat        = 1;
        halt_addr      = 16'hFFFF;
        @(negedge clk);
        #1;
        nchk++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else npass++;
        nchk++; if (instr_valid !== 1'b0) $display("FAIL rst_ivalid got %b exp 0", instr_valid); else npass++;
        nchk++; if (halted !== 1'b0) $display("FAIL rst_halted got %b exp 0", halted); else npass++;
        nchk++; if (align_err !== 1'b0) $display("FAIL rst_align got %b exp 0", align_err); else npass++;
        nchk++; if (instr !== 16'h0000) $display("FAIL rst_instr got %h exp 0000", instr); else npass++;
        nchk++; if (instr_pc !== 16'h0000) $display("FAIL rst_ipc got %h exp 0000", instr_pc); else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nchk++; if (imem_req !== 1'b1) $display("FAIL first_req got %b exp 1", imem_req); else npass++;
        nchk++; if (imem_addr !== 16'h0000) $display("FAIL first_addr got %h exp 0000", imem_addr); else npass++;
        step();
        step();
        nchk++; if (instr_valid !== 1'b1) $display("FAIL pre_mid_ivalid got %b exp 1", instr_valid); else npass++;
        rst_n = 1'b0;
        #1;
        nchk++; if (instr_valid !== 1'b0) $display("FAIL mid_rst_ivalid got %b exp 0", instr_valid); else npass++;
        nchk++; if (imem_req !== 1'b0) $display("FAIL mid_rst_req got %b exp 0", imem_req); else npass++;
    endtask

    task automatic test_stream();
        logic [15:0] ea;
        logic [15:0] ep;
        mem_lat   = 1;
        halt_addr = 16'hFFFF;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ea = 16'(2 * k);
            ep = 16'(2 * k - 2);
            nchk++; if (imem_req !== 1'b1) $display("FAIL str_req%0d got %b exp 1", k, imem_req); else npass++;
            nchk++; if (imem_addr !== ea) $display("FAIL str_addr%0d got %h exp %h", k, imem_addr, ea); else npass++;
            if (k > 0) begin
                nchk++; if (instr_valid !== 1'b1) $display("FAIL str_iv%0d got %b exp 1", k, instr_valid); else npass++;
                nchk++; if (instr !== (16'h4000 | ep)) $display("FAIL str_instr%0d got %h exp %h", k, instr, 16'h4000 | ep); else npass++;
                nchk++; if (instr_pc !== ep) $display("FAIL str_ipc%0d got %h exp %h", k, instr_pc, ep); else npass++;
                nchk++; if (instr_pc_2 !== ea) $display("FAIL str_ipc2_%0d got %h exp %h", k, instr_pc_2, ea); else npass++;
            end else begin
                nchk++; if (instr_valid !== 1'b0) $display("FAIL str_iv0 got %b exp 0", instr_valid); else npass++;
            end
            step();
            nchk++; if (instr_valid !== 1'b0) $display("FAIL str_gap_iv%0d got %b exp 0", k, instr_valid); else npass++;
            nchk++; if (imem_req !== 1'b0) $display("FAIL str_gap_req%0d got %b exp 0", k, imem_req); else npass++;
            step();
        end
    endtask

    task automatic test_ready_low();
        mem_lat   = 1;
        halt_addr = 16'hFFFF;
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_ready = 1'b1;
            #1;
            nchk++; if (imem_req !== 1'b1) $display("FAIL rdy_req%0d got %b exp 1", i, imem_req); else npass++;
            nchk++; if (imem_addr !== 16'h0000) $display("FAIL rdy_addr%0d got %h exp 0000", i, imem_addr); else npass++;
            step();
        end
        nchk++; if (imem_req !== 1'b0) $display("FAIL rdy_wait_req got %b exp 0", imem_req); else npass++;
        nchk++; if (instr_valid !== 1'b0) $display("FAIL rdy_wait_iv got %b exp 0", instr_valid); else npass++;
        step();
        nchk++; if (instr_valid !== 1'b1) $display("FAIL rdy_cap_iv got %b exp 1", instr_valid); else npass++;
        nchk++; if (instr !== 16'h4000) $display("FAIL rdy_cap_instr got %h exp 4000", instr); else npass++;
        step();
        nchk++; if (instr_valid !== 1'b0) $display("FAIL rdy_single got %b exp 0", instr_valid); else npass++;
    endtask

    task automatic test_stall();
        mem_lat   = 1;
        halt_addr = 16'hFFFF;
        do_reset();
        step();
        step();
        decode_stall = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            nchk++; if (imem_req !== 1'b0) $display("FAIL stl_req%0d got %b exp 0", i, imem_req); else npass++;
            nchk++; if (instr_valid !== 1'b1) $display("FAIL stl_iv%0d got %b exp 1", i, instr_valid); else npass++;
            nchk++; if (instr !== 16'h4000) $display("FAIL stl_instr%0d got %h exp 4000", i, instr); else npass++;
            step();
        end
        decode_stall = 1'b0;
        #1;
        nchk++; if (imem_req !== 1'b1) $display("FAIL stl_rel_req got %b exp 1", imem_req); else npass++;
        nchk++; if (imem_addr !== 16'h0002) $display("FAIL stl_rel_addr got %h exp 0002", imem_addr); else npass++;
    endtask

    task automatic test_redirect();
        mem_lat   = 2;
        halt_addr = 16'hFFFF;
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        #1;
        nchk++; if (imem_req !== 1'b0) $display("FAIL rd_wait_req got %b exp 0", imem_req); else npass++;
        step();
        redirect_valid = 1'b0;
        #1;
        nchk++; if (imem_valid !== 1'b1) $display("FAIL rd_stale_resp got %b exp 1", imem_valid); else npass++;
        nchk++; if (imem_req !== 1'b0) $display("FAIL rd_drop_req got %b exp 0", imem_req); else npass++;
        nchk++; if (instr_valid !== 1'b0) $display("FAIL rd_drop_iv got %b exp 0", instr_valid); else npass++;
        step();
        nchk++; if (instr_valid !== 1'b0) $display("FAIL rd_stale_iv got %b exp 0", instr_valid); else npass++;
        nchk++; if (imem_req !== 1'b1) $display("FAIL rd_new_req got %b exp 1", imem_req); else npass++;
        nchk++; if (imem_addr !== 16'h0100) $display("FAIL rd_new_addr got %h exp 0100", imem_addr); else npass++;
        step();
        step();
        step();
        nchk++; if (instr_valid !== 1'b1) $display("FAIL rd_cap_iv got %b exp 1", instr_valid); else npass++;
        nchk++; if (instr_pc !== 16'h0100) $display("FAIL rd_cap_ipc got %h exp 0100", instr_pc); else npass++;
        nchk++; if (instr !== 16'h4100) $display("FAIL rd_cap_instr got %h exp 4100", instr); else npass++;
    endtask

    task automatic test_halt();
        mem_lat   = 1;
        halt_addr = 16'h0006;
        do_reset();
        repeat (8) step();
        nchk++; if (halted !== 1'b1) $display("FAIL hlt_flag got %b exp 1", halted); else npass++;
        nchk++; if (instr_valid !== 1'b1) $display("FAIL hlt_iv got %b exp 1", instr_valid); else npass++;
        nchk++; if (instr_pc !== 16'h0006) $display("FAIL hlt_ipc got %h exp 0006", instr_pc); else npass++;
        nchk++; if (instr !== 16'h0000) $display("FAIL hlt_instr got %h exp 0000", instr); else npass++;
        for (int i = 0; i < 4; i++) begin
            nchk++; if (imem_req !== 1'b0) $display("FAIL hlt_req%0d got %b exp 0", i, imem_req); else npass++;
            step();
        end
        nchk++; if (halted !== 1'b1) $display("FAIL hlt_hold got %b exp 1", halted); else npass++;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        step();
        redirect_valid = 1'b0;
        #1;
        nchk++; if (halted !== 1'b0) $display("FAIL hlt_clr got %b exp 0", halted); else npass++;
        nchk++; if (imem_req !== 1'b1) $display("FAIL hlt_rd_req got %b exp 1", imem_req); else npass++;
        nchk++; if (imem_addr !== 16'h0020) $display("FAIL hlt_rd_addr got %h exp 0020", imem_addr); else npass++;
        nchk++; if (align_err !== 1'b0) $display("FAIL hlt_align got %b exp 0", align_err); else npass++;
    endtask

    task automatic test_align_wrap();
        mem_lat   = 1;
        halt_addr = 16'hFFFF;
        do_reset();
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0031;
        step();
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        #1;
        nchk++; if (align_err !== 1'b1) $display("FAIL al_pulse got %b exp 1", align_err); else npass++;
        nchk++; if (imem_req !== 1'b1) $display("FAIL al_req got %b exp 1", imem_req); else npass++;
        nchk++; if (imem_addr !== 16'h0030) $display("FAIL al_addr got %h exp 0030", imem_addr); else npass++;
        step();
        nchk++; if (align_err !== 1'b0) $display("FAIL al_end got %b exp 0", align_err); else npass++;
        step();
        nchk++; if (instr_pc !== 16'h0030) $display("FAIL al_ipc got %h exp 0030", instr_pc); else npass++;
        nchk++; if (instr !== 16'h4030) $display("FAIL al_instr got %h exp 4030", instr); else npass++;
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        #1;
        nchk++; if (align_err !== 1'b0) $display("FAIL wr_align got %b exp 0", align_err); else npass++;
        nchk++; if (imem_addr !== 16'hFFFE) $display("FAIL wr_addr got %h exp fffe", imem_addr); else npass++;
        step();
        step();
        nchk++; if (instr_pc !== 16'hFFFE) $display("FAIL wr_ipc got %h exp fffe", instr_pc); else npass++;
        nchk++; if (instr_pc_2 !== 16'h0000) $display("FAIL wr_ipc2 got %h exp 0000", instr_pc_2); else npass++;
        nchk++; if (imem_req !== 1'b1) $display("FAIL wr_req got %b exp 1", imem_req); else npass++;
        nchk++; if (imem_addr !== 16'h0000) $display("FAIL wr_next got %h exp 0000", imem_addr); else npass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_low();
        test_stall();
        test_redirect();
        test_halt();
        test_align_wrap();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
